// File: rtl/donkey_pkg.sv
// Types and constants for the donkey sprite controller.
// Holds the motion state enum, sprite dimensions and the derived
// position limits (ground row and rightmost column).
package donkey_pkg;

  import vga_pkg::*;

  typedef enum logic [1:0] {
    STAND = 2'd0,
    JUMP  = 2'd1,
    FALL  = 2'd2
  } state_t;

  localparam int unsigned DONKEY_WIDTH  = 48;
  localparam int unsigned DONKEY_HEIGHT = 64;
  localparam int unsigned GROUND_Y      = VER_PIXELS - DONKEY_HEIGHT;
  localparam int unsigned X_MAX         = HOR_PIXELS - DONKEY_WIDTH;

endpackage

// File: rtl/vga_pkg.sv
// VGA timing constants shared by the display pipeline.
// Provides the visible resolution used to bound sprite positions.
package vga_pkg;

  localparam int unsigned HOR_PIXELS = 1024;
  localparam int unsigned VER_PIXELS = 768;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector.
// Ports: clk, rst (async active-low), d (level input), rise (one-cycle
// pulse on a 0->1 transition of d).
// A level already high when reset releases does not count as an edge;
// d must be seen low at least once before a rise is reported.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic armed_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q     <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      d_q     <= d;
      armed_q <= armed_q | ~d;
    end
  end

  assign rise = d & ~d_q & armed_q;

endmodule

// File: rtl/donkey_ctl.sv
// Donkey sprite motion controller.
// Ports: clk, rst (async active-low), vsync (frame marker, rising edge),
// key_left/key_right/key_jump (synchronised levels), xpos/ypos (sprite
// top-left), facing_left (mirror), airborne (in JUMP or FALL).
// Motion advances once per frame; all outputs are registered.
module donkey_ctl
  import donkey_pkg::*;
#(
  parameter int unsigned STEP    = 2,
  parameter int unsigned JUMP_V0 = 12,
  parameter int unsigned GRAVITY = 1,
  parameter int unsigned V_MAX   = 12,
  parameter int unsigned START_X = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_jump,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        facing_left,
  output logic        airborne
);

  localparam logic [12:0] STEP_W   = 13'(STEP);
  localparam logic [12:0] XMAX_W   = 13'(X_MAX);
  localparam logic [12:0] GROUND_W = 13'(GROUND_Y);
  localparam logic [4:0]  V0_W     = 5'(JUMP_V0);
  localparam logic [4:0]  GRAV_W   = 5'(GRAVITY);
  localparam logic [5:0]  VMAX_W   = 6'(V_MAX);

  logic frame_tick;

  edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (vsync),
    .rise (frame_tick)
  );

  state_t      state_q, state_d;
  logic [4:0]  vel_q, vel_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic        face_q, face_d;
  logic        air_q, air_d;

  logic [12:0] x_dec, x_inc, y_ext, vel_ext, y_sum;
  logic [5:0]  vel_inc;

  always_comb begin
    state_d = state_q;
    vel_d   = vel_q;
    x_d     = x_q;
    y_d     = y_q;
    face_d  = face_q;
    x_dec   = {1'b0, x_q} - STEP_W;
    x_inc   = {1'b0, x_q} + STEP_W;
    y_ext   = {1'b0, y_q};
    vel_ext = {8'd0, vel_q};
    y_sum   = y_ext + vel_ext;
    vel_inc = {1'b0, vel_q} + {1'b0, GRAV_W};

    if (frame_tick) begin
      // Horizontal: 13-bit arithmetic, bit 12 of x_dec flags underflow.
      if (key_left && !key_right) begin
        x_d    = x_dec[12] ? 12'd0 : x_dec[11:0];
        face_d = 1'b1;
      end else if (key_right && !key_left) begin
        x_d    = (x_inc > XMAX_W) ? XMAX_W[11:0] : x_inc[11:0];
        face_d = 1'b0;
      end

      case (state_q)
        STAND: begin
          if (key_jump) begin
            state_d = JUMP;
            vel_d   = V0_W;
          end
        end
        JUMP: begin
          if (y_ext < vel_ext) begin
            // Ceiling hit: pin to row 0 rather than wrapping.
            y_d     = 12'd0;
            vel_d   = 5'd0;
            state_d = FALL;
          end else begin
            y_d = y_q - {7'd0, vel_q};
            if (vel_q <= GRAV_W) begin
              vel_d   = 5'd0;
              state_d = FALL;
            end else begin
              vel_d = vel_q - GRAV_W;
            end
          end
        end
        FALL: begin
          if (y_sum >= GROUND_W) begin
            y_d     = GROUND_W[11:0];
            vel_d   = 5'd0;
            state_d = STAND;
          end else begin
            y_d   = y_sum[11:0];
            vel_d = (vel_inc > VMAX_W) ? VMAX_W[4:0] : vel_inc[4:0];
          end
        end
        default: begin
          state_d = STAND;
          vel_d   = 5'd0;
        end
      endcase
    end

    air_d = (state_d != STAND);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= STAND;
      vel_q   <= 5'd0;
      x_q     <= 12'(START_X);
      y_q     <= GROUND_W[11:0];
      face_q  <= 1'b0;
      air_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vel_q   <= vel_d;
      x_q     <= x_d;
      y_q     <= y_d;
      face_q  <= face_d;
      air_q   <= air_d;
    end
  end

  assign xpos        = x_q;
  assign ypos        = y_q;
  assign facing_left = face_q;
  assign airborne    = air_q;

endmodule

// File: tb/tb_donkey_ctl.sv
// Directed self-checking bench for donkey_ctl.
module tb_donkey_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync;
  logic        key_left, key_right, key_jump;
  logic [11:0] xpos, ypos;
  logic        facing_left, airborne;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  donkey_ctl dut (
    .clk         (clk),
    .rst         (rst),
    .vsync       (vsync),
    .key_left    (key_left),
    .key_right   (key_right),
    .key_jump    (key_jump),
    .xpos        (xpos),
    .ypos        (ypos),
    .facing_left (facing_left),
    .airborne    (airborne)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame: vsync high for 3 cycles, low for 2; outputs settle well before return.
  task automatic frame();
    @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Expected ypos after each tick of a full jump from the ground.
  int jump_y [26] = '{704, 692, 681, 671, 662, 654, 647, 641, 636, 632, 629, 627, 626,
                      626, 627, 629, 632, 636, 641, 647, 654, 662, 671, 681, 692, 704};

  initial begin
    rst       = 1'b0;
    vsync     = 1'b0;
    key_left  = 1'b0;
    key_right = 1'b0;
    key_jump  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_x", xpos, 64);
    check_eq("rst_y", ypos, 704);
    check_eq("rst_face", facing_left, 0);
    check_eq("rst_air", airborne, 0);
    rst = 1'b1;

    // Idle frames after reset.
    for (int i = 0; i < 10; i++) begin
      frame();
      check_eq("idle_x", xpos, 64);
      check_eq("idle_y", ypos, 704);
      check_eq("idle_air", airborne, 0);
    end

    // Walk left to 4, then into the left wall.
    key_left = 1'b1;
    repeat (30) frame();
    check_eq("left_x4", xpos, 4);
    frame(); check_eq("left_x2", xpos, 2);
    frame(); check_eq("left_x0", xpos, 0);
    frame(); check_eq("left_sat", xpos, 0);
    check_eq("left_face", facing_left, 1);

    // Both keys: no move, facing held.
    key_right = 1'b1;
    for (int i = 0; i < 5; i++) begin
      frame();
      check_eq("both_x", xpos, 0);
      check_eq("both_face", facing_left, 1);
    end

    // Walk right to 974, then into the right wall.
    key_left = 1'b0;
    repeat (487) frame();
    check_eq("right_x974", xpos, 974);
    check_eq("right_face", facing_left, 0);
    frame(); check_eq("right_x976", xpos, 976);
    frame(); check_eq("right_sat", xpos, 976);
    key_right = 1'b0;

    // Full jump with a one-frame key_jump pulse.
    key_jump = 1'b1;
    frame();
    key_jump = 1'b0;
    check_eq("jump_y", ypos, jump_y[0]);
    check_eq("jump_air", airborne, 1);
    for (int i = 1; i < 26; i++) begin
      frame();
      check_eq("jump_y", ypos, jump_y[i]);
      check_eq("jump_air", airborne, (i < 25) ? 1 : 0);
    end
    check_eq("jump_x", xpos, 976);

    // vsync high across reset release must not tick until it falls and rises.
    @(negedge clk);
    rst   = 1'b0;
    vsync = 1'b1;
    repeat (2) @(negedge clk);
    key_left = 1'b1;
    rst      = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("vs_hold_x", xpos, 64);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("vs_rise_x", xpos, 62);
    vsync    = 1'b0;
    key_left = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a jump.
    key_jump = 1'b1;
    frame();
    key_jump = 1'b0;
    repeat (3) frame();
    check_eq("mid_y_pre", ypos, 671);
    check_eq("mid_air_pre", airborne, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_x", xpos, 64);
    check_eq("mid_rst_y", ypos, 704);
    check_eq("mid_rst_face", facing_left, 0);
    check_eq("mid_rst_air", airborne, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    frame();
    check_eq("post_rst_y", ypos, 704);
    check_eq("post_rst_air", airborne, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
